// File: rtl/multiboot_icap_seq_pkg.sv
// Shared constants, state encoding and word-selection helpers for the MultiBoot ICAP sequencer.
package multiboot_icap_seq_pkg;

  // ICAP sync words and type-1 packet headers
  localparam logic [15:0] SyncWord1  = 16'hAA99;
  localparam logic [15:0] SyncWord2  = 16'h5566;
  localparam logic [15:0] HdrCmdWr   = 16'h30A1;
  localparam logic [15:0] HdrGen1Wr  = 16'h3261;
  localparam logic [15:0] HdrGen2Wr  = 16'h3281;
  localparam logic [15:0] HdrModeWr  = 16'h3301;
  localparam logic [15:0] ModeValue  = 16'h3100;
  localparam logic [15:0] HdrGen5Wr  = 16'h32E1;
  localparam logic [15:0] CmdNull    = 16'h0000;
  localparam logic [15:0] CmdIprog   = 16'h000E;
  localparam logic [15:0] NoopWord   = 16'h2000;
  localparam logic [15:0] NullWord   = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StNoop,
    StDone
  } state_e;

  // Reverse bit order inside each byte, as the ICAP data pins expect.
  function automatic logic [15:0] bit_swap(logic [15:0] w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i]     = w[7-i];
      r[8+i]   = w[15-i];
    end
    return r;
  endfunction

  // Map packet index to word. idx counts only emitted words, so it is first
  // stretched onto the full 14-entry list by skipping disabled write pairs.
  function automatic logic [15:0] icap_word(logic [3:0]  idx,
                                            logic [23:0] addr,
                                            logic [15:0] uw,
                                            logic [7:0]  read_op,
                                            bit          quad,
                                            bit          gen5);
    logic [3:0]  c;
    logic [15:0] w;
    c = idx;
    if (!quad && c >= 4'd8)  c = c + 4'd2;
    if (!gen5 && c >= 4'd10) c = c + 4'd2;
    case (c)
      4'd0:    w = SyncWord1;
      4'd1:    w = SyncWord2;
      4'd2:    w = HdrCmdWr;
      4'd3:    w = CmdNull;
      4'd4:    w = HdrGen1Wr;
      4'd5:    w = addr[15:0];
      4'd6:    w = HdrGen2Wr;
      4'd7:    w = {read_op, addr[23:16]};
      4'd8:    w = HdrModeWr;
      4'd9:    w = ModeValue;
      4'd10:   w = HdrGen5Wr;
      4'd11:   w = uw;
      4'd12:   w = HdrCmdWr;
      4'd13:   w = CmdIprog;
      default: w = NoopWord;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/multiboot_icap_seq_req_filter.sv
// Reboot request conditioning: 2-FF synchroniser, debounce counter and re-arm latch.
module multiboot_icap_seq_req_filter #(
  parameter int unsigned FilterLen = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  output logic trig_o
);

  logic       req_s1_q, req_s2_q;
  logic [3:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;
  logic       trig_q, trig_d;

  // Synchroniser is left free-running through reset so that armed can see
  // whether the request is still held when reset is applied.
  always_ff @(posedge clk_i) begin
    req_s1_q <= req_i;
    req_s2_q <= req_s1_q;
  end

  // Saturating level counter, trigger decode and re-arm logic.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    trig_d  = 1'b0;
    if (!req_s2_q) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (cnt_q != 4'(FilterLen)) begin
      cnt_d = cnt_q + 4'd1;
    end
    if (armed_q && req_s2_q && (cnt_d == 4'(FilterLen)) && (cnt_q != 4'(FilterLen))) begin
      trig_d  = 1'b1;
      armed_d = 1'b0;
    end
  end

  // Filter state; reset disarms while the request is still high so a held
  // request cannot restart a freshly reset sequencer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      armed_q <= ~req_s2_q;
      trig_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      trig_q  <= trig_d;
    end
  end

  assign trig_o = trig_q;

endmodule

// File: rtl/multiboot_icap_seq.sv
// Spartan-6 MultiBoot sequencer: filters a reboot request, latches the target SPI
// address and streams the IPROG packet on registered ICAP-style outputs.
module multiboot_icap_seq
  import multiboot_icap_seq_pkg::*;
#(
  parameter int unsigned          SLOTS      = 4,
  parameter logic [SLOTS*24-1:0]  SLOT_BASE  = {24'h1C0000, 24'h160000, 24'h110000, 24'h0B0000},
  parameter logic [7:0]           READ_OP    = 8'h6B,
  parameter bit                   QUAD_MODE  = 1'b1,
  parameter bit                   WRITE_GEN5 = 1'b1,
  parameter int unsigned          NOOP_CNT   = 4,
  parameter int unsigned          FILTER_LEN = 4
) (
  input  logic        CLK,
  input  logic        MBT_RESET,
  input  logic        MBT_REBOOT,
  input  logic [2:0]  slot_sel,
  input  logic        addr_ovr_en,
  input  logic [23:0] addr_ovr,
  input  logic [15:0] user_word,
  output logic        busy,
  output logic        done,
  output logic        dbg_ce,
  output logic        dbg_wr,
  output logic [15:0] dbg_din
);

  localparam int unsigned NumWords = 10 + 2 * int'(QUAD_MODE) + 2 * int'(WRITE_GEN5);
  localparam logic [3:0]  LastIdx  = 4'(NumWords - 1);
  localparam logic [3:0]  LastNoop = 4'(NOOP_CNT - 1);

  logic        trig;
  logic [23:0] slot_addr;
  logic [15:0] cur_word;

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [3:0]  noop_q;
  logic [23:0] addr_q;
  logic [15:0] uw_q;
  logic        busy_q, done_q;
  logic        ce_q, wr_q;
  logic [15:0] din_q;

  multiboot_icap_seq_req_filter #(
    .FilterLen (FILTER_LEN)
  ) u_req_filter (
    .clk_i  (CLK),
    .rst_i  (MBT_RESET),
    .req_i  (MBT_REBOOT),
    .trig_o (trig)
  );

  // Slot table lookup; out-of-range selects fall back to slot 0.
  always_comb begin
    slot_addr = SLOT_BASE[23:0];
    for (int unsigned i = 1; i < SLOTS; i++) begin
      if (slot_sel == 3'(i)) slot_addr = SLOT_BASE[i*24 +: 24];
    end
  end

  // Word currently selected by the packet index.
  always_comb begin
    cur_word = icap_word(idx_q, addr_q, uw_q, READ_OP, QUAD_MODE, WRITE_GEN5);
  end

  // Sequencer FSM with registered ICAP outputs; pins lag the selected word by one cycle.
  always_ff @(posedge CLK) begin
    if (MBT_RESET) begin
      state_q <= StIdle;
      idx_q   <= '0;
      noop_q  <= '0;
      addr_q  <= '0;
      uw_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ce_q    <= 1'b1;
      wr_q    <= 1'b1;
      din_q   <= NullWord;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          ce_q  <= 1'b1;
          wr_q  <= 1'b1;
          din_q <= NullWord;
          if (trig) begin
            addr_q  <= addr_ovr_en ? addr_ovr : slot_addr;
            uw_q    <= user_word;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StSend;
          end
        end
        StSend: begin
          ce_q  <= 1'b0;
          wr_q  <= 1'b0;
          din_q <= bit_swap(cur_word);
          if (idx_q == LastIdx) begin
            idx_q   <= '0;
            noop_q  <= '0;
            state_q <= StNoop;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        StNoop: begin
          ce_q  <= 1'b0;
          wr_q  <= 1'b0;
          din_q <= bit_swap(NoopWord);
          if (noop_q == LastNoop) begin
            state_q <= StDone;
          end else begin
            noop_q <= noop_q + 4'd1;
          end
        end
        StDone: begin
          ce_q    <= 1'b1;
          wr_q    <= 1'b1;
          din_q   <= NullWord;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign dbg_ce  = ce_q;
  assign dbg_wr  = wr_q;
  assign dbg_din = din_q;

endmodule

// File: tb/tb_multiboot_icap_seq.sv
// Directed bench: a default instance (A) and a QUAD_MODE=0 instance (B) share all inputs.
module tb_multiboot_icap_seq;

  logic        clk = 1'b0;
  logic        MBT_RESET, MBT_REBOOT;
  logic [2:0]  slot_sel;
  logic        addr_ovr_en;
  logic [23:0] addr_ovr;
  logic [15:0] user_word;

  logic        busy_a, done_a, ce_a, wr_a;
  logic [15:0] din_a;
  logic        busy_b, done_b, ce_b, wr_b;
  logic [15:0] din_b;

  int errors = 0;
  int checks = 0;
  int rises  = 0;
  logic busy_prev = 1'b0;

  logic [15:0] exp_a [18];
  logic [15:0] exp_b [18];

  always #5 clk = ~clk;

  multiboot_icap_seq u_dut_a (
    .CLK (clk), .MBT_RESET (MBT_RESET), .MBT_REBOOT (MBT_REBOOT), .slot_sel (slot_sel),
    .addr_ovr_en (addr_ovr_en), .addr_ovr (addr_ovr), .user_word (user_word),
    .busy (busy_a), .done (done_a), .dbg_ce (ce_a), .dbg_wr (wr_a), .dbg_din (din_a)
  );

  multiboot_icap_seq #(.QUAD_MODE (1'b0)) u_dut_b (
    .CLK (clk), .MBT_RESET (MBT_RESET), .MBT_REBOOT (MBT_REBOOT), .slot_sel (slot_sel),
    .addr_ovr_en (addr_ovr_en), .addr_ovr (addr_ovr), .user_word (user_word),
    .busy (busy_b), .done (done_b), .dbg_ce (ce_b), .dbg_wr (wr_b), .dbg_din (din_b)
  );

  // Count packets started on instance A
  always @(negedge clk) begin
    busy_prev <= busy_a;
    if (busy_a && !busy_prev) rises <= rises + 1;
  end

  function automatic logic [15:0] swp(logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i]   = w[7-i];
      r[8+i] = w[15-i];
    end
    return r;
  endfunction

  task automatic check(string tag, string what, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  // Request for 6 cycles, then follow both instances word by word.
  task automatic run_packet(string tag, bit retrig);
    bit seen;
    int busy_cyc;
    MBT_REBOOT = 1'b1;
    repeat (6) @(negedge clk);
    MBT_REBOOT = 1'b0;
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      if (busy_a) seen = 1'b1;
    end
    check(tag, "busy_rise", 32'(seen), 32'd1);
    if (!seen) return;
    check(tag, "din_before_first", 32'(din_a), 32'h0000FFFF);
    check(tag, "ce_before_first", 32'(ce_a), 32'd1);
    // Inputs after trigger must be ignored
    slot_sel    = 3'd7;
    addr_ovr_en = ~addr_ovr_en;
    addr_ovr    = 24'hFFFFFF;
    user_word   = 16'h0000;
    busy_cyc    = 1;
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      if (retrig && k == 2)  MBT_REBOOT = 1'b1;
      if (retrig && k == 14) MBT_REBOOT = 1'b0;
      if (busy_a) busy_cyc++;
      if (k == 0) check(tag, "aa99_swapped", 32'(din_a), 32'h00005599);
      if (k < 18) begin
        check(tag, $sformatf("a_word%0d", k), 32'(din_a), 32'(swp(exp_a[k])));
        check(tag, $sformatf("a_cewr%0d", k), 32'({ce_a, wr_a}), 32'd0);
      end else begin
        check(tag, "a_done", 32'(done_a), 32'd1);
        check(tag, "a_busy_fall", 32'(busy_a), 32'd0);
        check(tag, "a_idle_din", 32'(din_a), 32'h0000FFFF);
        check(tag, "a_idle_cewr", 32'({ce_a, wr_a}), 32'd3);
      end
      if (k < 16) begin
        check(tag, $sformatf("b_word%0d", k), 32'(din_b), 32'(swp(exp_b[k])));
        check(tag, $sformatf("b_ce%0d", k), 32'(ce_b), 32'd0);
      end else if (k == 16) begin
        check(tag, "b_done", 32'(done_b), 32'd1);
        check(tag, "b_idle_din", 32'(din_b), 32'h0000FFFF);
      end
    end
    check(tag, "busy_cycles", 32'(busy_cyc), 32'd19);
    @(negedge clk);
    check(tag, "done_one_cycle", 32'(done_a), 32'd0);
  endtask

  initial begin
    int r0;
    MBT_RESET   = 1'b1;
    MBT_REBOOT  = 1'b0;
    slot_sel    = 3'd0;
    addr_ovr_en = 1'b0;
    addr_ovr    = 24'h0;
    user_word   = 16'h0;
    repeat (4) @(negedge clk);
    MBT_RESET = 1'b0;
    @(negedge clk);
    check("reset", "busy", 32'({busy_a, busy_b}), 32'd0);
    check("reset", "done", 32'({done_a, done_b}), 32'd0);
    check("reset", "ce_wr", 32'({ce_a, wr_a, ce_b, wr_b}), 32'hF);
    check("reset", "din_a", 32'(din_a), 32'h0000FFFF);
    check("reset", "din_b", 32'(din_b), 32'h0000FFFF);

    // Slot 0, default parameters
    slot_sel = 3'd0; addr_ovr_en = 1'b0; user_word = 16'h1234;
    exp_a = '{16'hAA99, 16'h5566, 16'h30A1, 16'h0000, 16'h3261, 16'h0000, 16'h3281, 16'h6B0B,
              16'h3301, 16'h3100, 16'h32E1, 16'h1234, 16'h30A1, 16'h000E,
              16'h2000, 16'h2000, 16'h2000, 16'h2000};
    exp_b = '{16'hAA99, 16'h5566, 16'h30A1, 16'h0000, 16'h3261, 16'h0000, 16'h3281, 16'h6B0B,
              16'h32E1, 16'h1234, 16'h30A1, 16'h000E, 16'h2000, 16'h2000, 16'h2000, 16'h2000,
              16'hFFFF, 16'hFFFF};
    run_packet("p1_slot0", 1'b0);
    repeat (3) @(negedge clk);

    // Slot 2
    slot_sel = 3'd2; addr_ovr_en = 1'b0; user_word = 16'hBEEF;
    exp_a = '{16'hAA99, 16'h5566, 16'h30A1, 16'h0000, 16'h3261, 16'h0000, 16'h3281, 16'h6B16,
              16'h3301, 16'h3100, 16'h32E1, 16'hBEEF, 16'h30A1, 16'h000E,
              16'h2000, 16'h2000, 16'h2000, 16'h2000};
    exp_b = '{16'hAA99, 16'h5566, 16'h30A1, 16'h0000, 16'h3261, 16'h0000, 16'h3281, 16'h6B16,
              16'h32E1, 16'hBEEF, 16'h30A1, 16'h000E, 16'h2000, 16'h2000, 16'h2000, 16'h2000,
              16'hFFFF, 16'hFFFF};
    run_packet("p2_slot2", 1'b0);
    repeat (3) @(negedge clk);

    // Address override
    slot_sel = 3'd1; addr_ovr_en = 1'b1; addr_ovr = 24'h2C8000; user_word = 16'h5A01;
    exp_a = '{16'hAA99, 16'h5566, 16'h30A1, 16'h0000, 16'h3261, 16'h8000, 16'h3281, 16'h6B2C,
              16'h3301, 16'h3100, 16'h32E1, 16'h5A01, 16'h30A1, 16'h000E,
              16'h2000, 16'h2000, 16'h2000, 16'h2000};
    exp_b = '{16'hAA99, 16'h5566, 16'h30A1, 16'h0000, 16'h3261, 16'h8000, 16'h3281, 16'h6B2C,
              16'h32E1, 16'h5A01, 16'h30A1, 16'h000E, 16'h2000, 16'h2000, 16'h2000, 16'h2000,
              16'hFFFF, 16'hFFFF};
    run_packet("p3_ovr", 1'b0);
    repeat (3) @(negedge clk);

    // Request one cycle too short
    r0 = rises;
    MBT_REBOOT = 1'b1;
    repeat (3) @(negedge clk);
    MBT_REBOOT = 1'b0;
    repeat (20) @(negedge clk);
    check("short_req", "no_trigger", 32'(rises - r0), 32'd0);

    // Slot 1 with a second request while busy
    r0 = rises;
    slot_sel = 3'd1; addr_ovr_en = 1'b0; user_word = 16'hC0DE;
    exp_a = '{16'hAA99, 16'h5566, 16'h30A1, 16'h0000, 16'h3261, 16'h0000, 16'h3281, 16'h6B11,
              16'h3301, 16'h3100, 16'h32E1, 16'hC0DE, 16'h30A1, 16'h000E,
              16'h2000, 16'h2000, 16'h2000, 16'h2000};
    exp_b = '{16'hAA99, 16'h5566, 16'h30A1, 16'h0000, 16'h3261, 16'h0000, 16'h3281, 16'h6B11,
              16'h32E1, 16'hC0DE, 16'h30A1, 16'h000E, 16'h2000, 16'h2000, 16'h2000, 16'h2000,
              16'hFFFF, 16'hFFFF};
    run_packet("p4_retrig", 1'b1);
    repeat (20) @(negedge clk);
    check("p4_retrig", "single_packet", 32'(rises - r0), 32'd1);

    // Reset in the middle of a packet with the request held high
    slot_sel = 3'd0; addr_ovr_en = 1'b0; user_word = 16'h1234;
    MBT_REBOOT = 1'b1;
    for (int w = 0; w < 30 && !busy_a; w++) @(negedge clk);
    check("mid_reset", "started", 32'(busy_a), 32'd1);
    repeat (6) @(negedge clk);
    check("mid_reset", "mid_ce", 32'(ce_a), 32'd0);
    MBT_RESET = 1'b1;
    @(negedge clk);
    check("mid_reset", "busy_cleared", 32'(busy_a), 32'd0);
    MBT_RESET = 1'b0;
    @(negedge clk);
    check("mid_reset", "cewr_idle", 32'({ce_a, wr_a}), 32'd3);
    check("mid_reset", "din_idle", 32'(din_a), 32'h0000FFFF);
    check("mid_reset", "done_low", 32'(done_a), 32'd0);
    r0 = rises;
    repeat (20) @(negedge clk);
    check("mid_reset", "no_retrigger", 32'(rises - r0), 32'd0);
    check("mid_reset", "still_idle", 32'(busy_a), 32'd0);
    MBT_REBOOT = 1'b0;
    repeat (4) @(negedge clk);
    exp_a = '{16'hAA99, 16'h5566, 16'h30A1, 16'h0000, 16'h3261, 16'h0000, 16'h3281, 16'h6B0B,
              16'h3301, 16'h3100, 16'h32E1, 16'h1234, 16'h30A1, 16'h000E,
              16'h2000, 16'h2000, 16'h2000, 16'h2000};
    exp_b = '{16'hAA99, 16'h5566, 16'h30A1, 16'h0000, 16'h3261, 16'h0000, 16'h3281, 16'h6B0B,
              16'h32E1, 16'h1234, 16'h30A1, 16'h000E, 16'h2000, 16'h2000, 16'h2000, 16'h2000,
              16'hFFFF, 16'hFFFF};
    run_packet("p5_after_reset", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
